// File: rtl/return_stack.sv
// ============================================================================
// return_stack : parametrised LIFO for subroutine return addresses with
//                zero-latency top read, optional wrap-on-full, sticky errors.
// Revision 1.0
// ============================================================================
`default_nettype none

module return_stack #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8,
  parameter int WRAP  = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  input  logic                       clr_err,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] C_WP_LAST = PW'(DEPTH-1);
  localparam logic [CW-1:0] C_CNT_MAX = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wp_q, wp_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic [PW-1:0]    wp_inc, wp_dec;
  logic             is_empty, is_full;
  logic             ovf_set, unf_set;

  // Pointer wrap uses explicit compares so DEPTH need not be a power of two.
  assign wp_inc   = (wp_q == C_WP_LAST) ? '0 : wp_q + PW'(1);
  assign wp_dec   = (wp_q == '0) ? C_WP_LAST : wp_q - PW'(1);
  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == C_CNT_MAX);

  always_comb begin
    mem_d   = mem_q;
    wp_d    = wp_q;
    count_d = count_q;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    case ({push, pop})
      2'b10: begin
        if (!is_full) begin
          mem_d[wp_q] = din;
          wp_d        = wp_inc;
          count_d     = count_q + CW'(1);
        end else begin
          ovf_set = 1'b1;
          if (WRAP != 0) begin
            mem_d[wp_q] = din;
            wp_d        = wp_inc;
          end
        end
      end
      2'b01: begin
        if (!is_empty) begin
          wp_d    = wp_dec;
          count_d = count_q - CW'(1);
        end else begin
          unf_set = 1'b1;
        end
      end
      2'b11: begin
        if (!is_empty) begin
          mem_d[wp_dec] = din;
        end else begin
          // Replace on an empty stack degrades to a plain push.
          mem_d[wp_q] = din;
          wp_d        = wp_inc;
          count_d     = CW'(1);
          unf_set     = 1'b1;
        end
      end
      default: ;
    endcase
    ovf_d = ovf_set | (ovf_q & ~clr_err);
    unf_d = unf_set | (unf_q & ~clr_err);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wp_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      wp_q    <= wp_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q <= mem_d;
    end
  end

  assign dout      = is_empty ? '0 : mem_q[wp_dec];
  assign count     = count_q;
  assign empty     = is_empty;
  assign full      = is_full;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

`default_nettype wire

// File: tb/tb_return_stack.sv
// ============================================================================
// tb_return_stack : directed bench driving a drop-on-full and a wrap-on-full
//                   stack with identical stimulus.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_return_stack;

  logic       clk = 1'b0;
  logic       reset, push, pop, clr_err;
  logic [9:0] din;

  logic [9:0] dout0, dout1;
  logic [3:0] count0, count1;
  logic       empty0, empty1, full0, full1;
  logic       ovf0, ovf1, unf0, unf1;

  int total_cnt = 0;
  int pass_cnt  = 0;

  always #5 clk = ~clk;

  return_stack #(.WIDTH(10), .DEPTH(8), .WRAP(0)) u_drop (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .din(din),
    .clr_err(clr_err), .dout(dout0), .count(count0), .empty(empty0),
    .full(full0), .overflow(ovf0), .underflow(unf0)
  );

  return_stack #(.WIDTH(10), .DEPTH(8), .WRAP(1)) u_wrap (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .din(din),
    .clr_err(clr_err), .dout(dout1), .count(count1), .empty(empty1),
    .full(full1), .overflow(ovf1), .underflow(unf1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step(input logic p, input logic po, input logic [9:0] d, input logic c);
    push = p; pop = po; din = d; clr_err = c;
    @(posedge clk);
    #1;
  endtask

  // Same expectation on both instances.
  task automatic chk2(input string tag, input logic [31:0] d, input logic [31:0] n,
                      input logic [31:0] o, input logic [31:0] u);
    chk({tag, "_dout0"}, 32'(dout0), d);  chk({tag, "_dout1"}, 32'(dout1), d);
    chk({tag, "_cnt0"},  32'(count0), n); chk({tag, "_cnt1"},  32'(count1), n);
    chk({tag, "_ovf0"},  32'(ovf0), o);   chk({tag, "_ovf1"},  32'(ovf1), o);
    chk({tag, "_unf0"},  32'(unf0), u);   chk({tag, "_unf1"},  32'(unf1), u);
  endtask

  initial begin
    // Reset held low while pushing: nothing may be written.
    reset = 1'b0;
    step(1'b1, 1'b0, 10'h3FF, 1'b0);
    reset = 1'b1;
    chk2("rst", 0, 0, 0, 0);
    chk("rst_empty", 32'(empty0), 1);
    chk("rst_full",  32'(full0), 0);
    step(1'b0, 1'b0, 10'h000, 1'b0);
    chk2("rst_idle", 0, 0, 0, 0);

    // LIFO order
    step(1'b1, 1'b0, 10'h011, 1'b0); chk2("lifo_p1", 32'h011, 1, 0, 0);
    step(1'b1, 1'b0, 10'h022, 1'b0); chk2("lifo_p2", 32'h022, 2, 0, 0);
    step(1'b1, 1'b0, 10'h033, 1'b0); chk2("lifo_p3", 32'h033, 3, 0, 0);
    step(1'b0, 1'b1, 10'h000, 1'b0); chk2("lifo_q1", 32'h022, 2, 0, 0);
    step(1'b0, 1'b1, 10'h000, 1'b0); chk2("lifo_q2", 32'h011, 1, 0, 0);
    step(1'b0, 1'b1, 10'h000, 1'b0); chk2("lifo_q3", 0, 0, 0, 0);
    chk("lifo_empty", 32'(empty0), 1);

    // Fill to capacity, then one more push
    for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 10'(i), 1'b0);
    chk2("fill8", 8, 8, 0, 0);
    chk("fill8_full0", 32'(full0), 1);
    chk("fill8_full1", 32'(full1), 1);
    step(1'b1, 1'b0, 10'd9, 1'b0);
    chk("ovf_dout0", 32'(dout0), 8);  chk("ovf_dout1", 32'(dout1), 9);
    chk("ovf_cnt0", 32'(count0), 8);  chk("ovf_cnt1", 32'(count1), 8);
    chk("ovf_flag0", 32'(ovf0), 1);   chk("ovf_flag1", 32'(ovf1), 1);
    chk("ovf_full0", 32'(full0), 1);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain%0d_dout0", i), 32'(dout0), 32'(8 - i));
      chk($sformatf("drain%0d_dout1", i), 32'(dout1), 32'(9 - i));
      step(1'b0, 1'b1, 10'h000, 1'b0);
    end
    chk2("drained", 0, 0, 1, 0);
    step(1'b0, 1'b0, 10'h000, 1'b1);
    chk2("clr_ovf", 0, 0, 0, 0);

    // Simultaneous push and pop
    step(1'b1, 1'b0, 10'd5, 1'b0); chk2("sim_p5", 5, 1, 0, 0);
    step(1'b1, 1'b1, 10'd7, 1'b0); chk2("sim_rep7", 7, 1, 0, 0);
    step(1'b0, 1'b1, 10'd0, 1'b0); chk2("sim_pop", 0, 0, 0, 0);
    step(1'b1, 1'b1, 10'd3, 1'b0); chk2("sim_empty3", 3, 1, 0, 1);
    step(1'b0, 1'b1, 10'd0, 1'b0);
    step(1'b0, 1'b0, 10'd0, 1'b1); chk2("sim_clr", 0, 0, 0, 0);

    // Sticky underflow and clear priority
    step(1'b0, 1'b1, 10'd0, 1'b0); chk2("unf_set", 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 10'd0, 1'b0);
      chk($sformatf("unf_hold%0d", i), 32'(unf0), 1);
    end
    step(1'b0, 1'b1, 10'd0, 1'b1); chk2("unf_clr_pop", 0, 0, 0, 1);
    step(1'b0, 1'b0, 10'd0, 1'b1); chk2("unf_clr", 0, 0, 0, 0);

    // Reset in the middle of a pop on a non-empty stack
    step(1'b1, 1'b0, 10'h155, 1'b0);
    step(1'b1, 1'b0, 10'h0AA, 1'b0); chk2("pre_rst", 32'h0AA, 2, 0, 0);
    reset = 1'b0;
    step(1'b0, 1'b1, 10'd0, 1'b0);
    reset = 1'b1;
    chk2("mid_rst", 0, 0, 0, 0);
    step(1'b1, 1'b0, 10'h2C3, 1'b0); chk2("post_rst", 32'h2C3, 1, 0, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire
